alu_redundancy_ctrl: RTL and testbench

Sequencer that sits in front of the shared 32-bit ALU and provides time-redundant execution for fault detection. Each accepted request is executed twice on the ALU and the two results are compared. On mismatch the operation is retried up to MAX_RETRY times. Persistent mismatch is reported as a fault on the response channel and counted in a saturating fault counter.

---
 rtl/alu_redundancy_ctrl_pkg.sv | 33 +++
 rtl/alu_redundancy_ctrl_if.sv | 55 +++++
 rtl/alu_redundancy_ctrl_fault_sat_counter.sv | 24 ++
 rtl/alu_redundancy_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_redundancy_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_redundancy_ctrl_pkg.sv
// Shared definitions for the time-redundant ALU sequencer.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a. Contents: opcode constants, FSM state enum, fault pattern, helper functions.
package alu_redundancy_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // Result returned for both unrecoverable mismatches and illegal opcodes.
    localparam logic [31:0] FAULT_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC1,
        ST_EXEC2,
        ST_CHECK,
        ST_RESP
    } state_t;

    // Codes above OP_XOR are reported as illegal.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

    // Width of the retry counter; kept at least 1 bit so MAX_RETRY=0 still elaborates.
    function automatic int retry_w(input int max_retry);
        return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
    endfunction

endpackage

// File: rtl/alu_redundancy_ctrl_if.sv
// Bundle of request, response and ALU-side signals of the redundancy sequencer.
// Latency: n/a (wiring only). Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Modports: slave = sequencer view, master = requester/ALU/environment view. ALU_FAULT_INJECT_EN adds inject_mask.
interface alu_redundancy_ctrl_if import alu_redundancy_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) ();
    localparam int RW = retry_w(MAX_RETRY);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_fault;
    logic             rsp_illegal;
    logic [RW-1:0]    rsp_retries;

    logic [CNT_W-1:0] fault_count;
    logic             busy;
`ifdef ALU_FAULT_INJECT_EN
    logic [WIDTH-1:0] inject_mask;
`endif

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
`ifdef ALU_FAULT_INJECT_EN
        input  inject_mask,
`endif
        output req_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_result, rsp_fault, rsp_illegal, rsp_retries,
        output fault_count, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
`ifdef ALU_FAULT_INJECT_EN
        output inject_mask,
`endif
        input  req_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_result, rsp_fault, rsp_illegal, rsp_retries,
        input  fault_count, busy
    );

endinterface

// File: rtl/alu_redundancy_ctrl_fault_sat_counter.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
// Latency: count_o updates on the edge after inc_i is sampled high.
// Backpressure: none. Ports: clk, rst_n (async active-low clear), inc_i, count_o.
module fault_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/alu_redundancy_ctrl.sv
// Time-redundant sequencer: runs each request twice on the shared ALU, compares, retries up to MAX_RETRY.
// Latency: response valid 1+3*attempts cycles after accept (clean op: 4), illegal opcode: 1.
// Backpressure: one request in flight; req_ready only in IDLE; response held until rsp_ready. Ports: clk, rst_n, bus (slave). Option: ALU_FAULT_INJECT_EN.
module alu_redundancy_ctrl import alu_redundancy_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_redundancy_ctrl_if.slave bus
);
    localparam int RW = retry_w(MAX_RETRY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic             fault_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            r1_q          <= '0;
            r2_q          <= '0;
            retry_cnt_q   <= '0;
            rsp_result_q  <= '0;
            rsp_fault_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            r1_q          <= r1_d;
            r2_q          <= r2_d;
            retry_cnt_q   <= retry_cnt_d;
            rsp_result_q  <= rsp_result_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        r1_d          = r1_q;
        r2_d          = r2_q;
        retry_cnt_d   = retry_cnt_q;
        rsp_result_d  = rsp_result_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_illegal_d = rsp_illegal_q;
        fault_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is exactly state==IDLE, so req_valid alone is the handshake here.
                if (bus.req_valid) begin
                    alu_a_d     = bus.req_a;
                    alu_b_d     = bus.req_b;
                    alu_op_d    = bus.req_op;
                    retry_cnt_d = '0;
                    if (is_legal_op(bus.req_op)) begin
                        state_d = ST_EXEC1;
                    end else begin
                        // Illegal opcodes bypass the ALU entirely.
                        rsp_result_d  = WIDTH'(FAULT_PATTERN);
                        rsp_fault_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_EXEC1: begin
                r1_d    = bus.alu_result;
                state_d = ST_EXEC2;
            end
            ST_EXEC2: begin
`ifdef ALU_FAULT_INJECT_EN
                r2_d = bus.alu_result ^ bus.inject_mask;
`else
                r2_d = bus.alu_result;
`endif
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                rsp_illegal_d = 1'b0;
                if (r1_q == r2_q) begin
                    rsp_result_d = r1_q;
                    rsp_fault_d  = 1'b0;
                    state_d      = ST_RESP;
                end else if (retry_cnt_q != RW'(MAX_RETRY)) begin
                    // Operands are still held in alu_*; simply run both executions again.
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    state_d     = ST_EXEC1;
                end else begin
                    rsp_result_d = WIDTH'(FAULT_PATTERN);
                    rsp_fault_d  = 1'b1;
                    fault_inc    = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    fault_sat_counter #(
        .CNT_W (CNT_W)
    ) u_fault_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (fault_inc),
        .count_o (bus.fault_count)
    );

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_fault   = rsp_fault_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.rsp_retries = retry_cnt_q;

endmodule

// File: tb/tb_alu_redundancy_ctrl.sv
// Self-checking bench for alu_redundancy_ctrl with a behavioural ALU that can glitch on demand.
// Latency: n/a. Backpressure: exercised by holding rsp_ready low.
// Expected values come from opcode arithmetic and the attempt/latency rules, not from the RTL.
module tb_alu_redundancy_ctrl;
    import alu_redundancy_pkg::*;

    localparam int W  = 32;
    localparam int MR = 2;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_redundancy_ctrl_if #(.WIDTH(W), .MAX_RETRY(MR), .CNT_W(CW)) bus ();

    alu_redundancy_ctrl #(.WIDTH(W), .MAX_RETRY(MR), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   exp_fcnt  = 0;
    logic glitch    = 1'b0;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // The external ALU; glitch corrupts bit 8 of whatever it is computing this cycle.
    always_comb bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op) ^ (glitch ? 32'h0000_0100 : 32'h0);

    // Issues one request with rsp_ready high. nb = number of leading attempts whose second
    // execution sees a corrupted ALU result. lat = cycle (accept edge = 0) where rsp_valid is seen.
    task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input int nb, output int lat, output logic [W-1:0] res,
                           output logic flt, output logic ill, output logic [1:0] rtr);
        int g;
        lat = -1; res = '0; flt = 1'b0; ill = 1'b0; rtr = '0;
        bus.rsp_ready = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            // Attempt k occupies cycles 3k+1 (first run) and 3k+2 (second run).
            glitch = ((c % 3) == 2) && ((c / 3) < nb);
            if (bus.rsp_valid) begin
                lat = c;
                res = bus.rsp_result;
                flt = bus.rsp_fault;
                ill = bus.rsp_illegal;
                rtr = bus.rsp_retries;
                break;
            end
            @(posedge clk); #1;
        end
        glitch = 1'b0;
        if (lat >= 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_fault, bus.rsp_illegal} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_fault, bus.rsp_illegal});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin
            failures++;
            $display("FAIL reset_alu_regs: got a=%h b=%h op=%h expected zero", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_retries, bus.fault_count} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got res=%h rtr=%0d fcnt=%0d expected zero",
                     bus.rsp_result, bus.rsp_retries, bus.fault_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        run_req(32'd5, 32'd7, OP_ADD, 0, lat, res, flt, ill, rtr);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL add_latency: got %0d expected 4", lat); end
        checks++;
        if ({res, flt, ill, rtr} !== {32'd12, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL add_rsp: got res=%h f=%b i=%b r=%0d expected res=0000000c f=0 i=0 r=0", res, flt, ill, rtr);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        run_req(32'd9, 32'd4, 3'b111, 0, lat, res, flt, ill, rtr);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
        checks++;
        if ({res, flt, ill} !== {32'hDEAD_BEEF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_rsp: got res=%h f=%b i=%b expected deadbeef f=0 i=1", res, flt, ill);
        end
        checks++;
        if (bus.fault_count !== CW'(exp_fcnt)) begin
            failures++; $display("FAIL illegal_fcnt: got %0d expected %0d", bus.fault_count, exp_fcnt);
        end
    endtask

    task automatic test_recover();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        run_req(32'hA5, 32'h0F, OP_XOR, 1, lat, res, flt, ill, rtr);
        checks++;
        if (lat !== 7) begin failures++; $display("FAIL recover_latency: got %0d expected 7", lat); end
        checks++;
        if ({res, flt, rtr} !== {32'hAA, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL recover_rsp: got res=%h f=%b r=%0d expected 000000aa f=0 r=1", res, flt, rtr);
        end
        checks++;
        if (bus.fault_count !== CW'(exp_fcnt)) begin
            failures++; $display("FAIL recover_fcnt: got %0d expected %0d", bus.fault_count, exp_fcnt);
        end
    endtask

    task automatic test_fault();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        run_req(32'd10, 32'd3, OP_SUB, MR + 1, lat, res, flt, ill, rtr);
        exp_fcnt++;
        checks++;
        if (lat !== 10) begin failures++; $display("FAIL fault_latency: got %0d expected 10", lat); end
        checks++;
        if ({res, flt, ill, rtr} !== {32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL fault_rsp: got res=%h f=%b i=%b r=%0d expected deadbeef f=1 i=0 r=2", res, flt, ill, rtr);
        end
        checks++;
        if (bus.fault_count !== CW'(exp_fcnt)) begin
            failures++; $display("FAIL fault_fcnt: got %0d expected %0d", bus.fault_count, exp_fcnt);
        end
    endtask

    task automatic test_random();
        int lat, nb, e_lat, e_rtr; logic [W-1:0] res, a, b, e_res; logic [2:0] op;
        logic flt, ill, e_flt, e_ill; logic [1:0] rtr;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            nb = $urandom_range(0, 3);
            if (op > 3'd4) begin
                e_lat = 1; e_res = 32'hDEAD_BEEF; e_flt = 1'b0; e_ill = 1'b1; e_rtr = 0;
            end else if (nb > MR) begin
                e_lat = 1 + 3 * (MR + 1); e_res = 32'hDEAD_BEEF; e_flt = 1'b1; e_ill = 1'b0; e_rtr = MR;
                if (exp_fcnt < (1 << CW) - 1) exp_fcnt++;
            end else begin
                e_lat = 1 + 3 * (nb + 1); e_res = ref_alu(a, b, op); e_flt = 1'b0; e_ill = 1'b0; e_rtr = nb;
            end
            run_req(a, b, op, nb, lat, res, flt, ill, rtr);
            checks++;
            if (lat !== e_lat || {res, flt, ill, rtr} !== {e_res, e_flt, e_ill, 2'(e_rtr)}) begin
                failures++;
                $display("FAIL random_%0d: op=%0d nb=%0d got lat=%0d res=%h f=%b i=%b r=%0d expected lat=%0d res=%h f=%b i=%b r=%0d",
                         i, op, nb, lat, res, flt, ill, rtr, e_lat, e_res, e_flt, e_ill, e_rtr);
            end
            checks++;
            if (bus.fault_count !== CW'(exp_fcnt)) begin
                failures++; $display("FAIL random_fcnt_%0d: got %0d expected %0d", i, bus.fault_count, exp_fcnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int g; logic [W-1:0] res;
        bus.rsp_ready = 1'b0;
        bus.req_a = 32'd20; bus.req_b = 32'd22; bus.req_op = OP_ADD;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        // Keep a second request pending for the whole response stall.
        bus.req_a = 32'd100; bus.req_b = 32'd1;
        g = 0;
        while (!bus.rsp_valid && g < 20) begin @(posedge clk); #1; g++; end
        checks++;
        if (!bus.rsp_valid) begin failures++; $display("FAIL bp_timeout: rsp_valid=0 expected 1"); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_fault} !== {1'b1, 1'b0, 32'd42, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b res=%h f=%b expected v=1 rdy=0 res=0000002a f=0",
                         k, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_fault);
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_idle_gap: got v=%b rdy=%b busy=%b expected 0 1 0", bus.rsp_valid, bus.req_ready, bus.busy);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept: busy=%b expected 1", bus.busy); end
        g = 0;
        while (!bus.rsp_valid && g < 20) begin @(posedge clk); #1; g++; end
        res = bus.rsp_result;
        checks++;
        if (res !== 32'd101) begin failures++; $display("FAIL bp_second_rsp: got %h expected 00000065", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        bus.rsp_ready = 1'b1;
        bus.req_a = 32'd3; bus.req_b = 32'd4; bus.req_op = OP_OR; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_fault, bus.rsp_illegal} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_ctrl: got %b expected 10000",
                     {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_fault, bus.rsp_illegal});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_result, bus.rsp_retries, bus.fault_count} !== '0) begin
            failures++;
            $display("FAIL midreset_regs: got a=%h b=%h res=%h fcnt=%0d expected zero",
                     bus.alu_a, bus.alu_b, bus.rsp_result, bus.fault_count);
        end
        exp_fcnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(32'd1, 32'd1, OP_ADD, 0, lat, res, flt, ill, rtr);
        checks++;
        if (lat !== 4 || res !== 32'd2 || bus.fault_count !== '0) begin
            failures++;
            $display("FAIL midreset_after: got lat=%0d res=%h fcnt=%0d expected 4 00000002 0", lat, res, bus.fault_count);
        end
    endtask

`ifdef ALU_FAULT_INJECT_EN
    task automatic test_inject();
        int lat; logic [W-1:0] res; logic flt, ill; logic [1:0] rtr;
        bus.inject_mask = 32'd1;
        run_req(32'd10, 32'd3, OP_SUB, 0, lat, res, flt, ill, rtr);
        bus.inject_mask = '0;
        exp_fcnt++;
        checks++;
        if (lat !== 10 || {res, flt, rtr} !== {32'hDEAD_BEEF, 1'b1, 2'd2} || bus.fault_count !== CW'(exp_fcnt)) begin
            failures++;
            $display("FAIL inject_const: got lat=%0d res=%h f=%b r=%0d fcnt=%0d expected 10 deadbeef 1 2 %0d",
                     lat, res, flt, rtr, bus.fault_count, exp_fcnt);
        end
        // Mask only while the first attempt's second run is captured (cycles 1..2).
        bus.rsp_ready = 1'b1;
        bus.req_a = 32'hA5; bus.req_b = 32'h0F; bus.req_op = OP_XOR; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.inject_mask = 32'd1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) bus.inject_mask = '0;
            if (bus.rsp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== 7 || {bus.rsp_result, bus.rsp_fault, bus.rsp_retries} !== {32'hAA, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL inject_once: got lat=%0d res=%h f=%b r=%0d expected 7 000000aa 0 1",
                     lat, bus.rsp_result, bus.rsp_fault, bus.rsp_retries);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef ALU_FAULT_INJECT_EN
        bus.inject_mask = '0;
`endif
        test_reset();
        test_add();
        test_illegal();
        test_recover();
        test_fault();
`ifdef ALU_FAULT_INJECT_EN
        test_inject();
`endif
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
